// File: rtl/tick_sched.sv
// tick_sched
// ----------
// Run-time programmable time base. A single prescale counter divides clk
// into a square out_clk and a one-cycle tick enable that fires on every
// out_clk toggle. The half-period terminal count and the run mode
// (continuous or one-shot) are written through a valid/ready port; start
// and stop sequence the counter between IDLE and RUN.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   cfg_valid    configuration request
//   cfg_ready    configuration accepted when cfg_valid && cfg_ready
//   cfg_half     requested half-period terminal count (toggle every half+1)
//   cfg_oneshot  0 = continuous, 1 = one-shot (one full out_clk period)
//   start        begin counting (level sampled each cycle)
//   stop         abort counting (wins over start and terminal count)
//   out_clk      divided square wave
//   tick         one-cycle pulse coincident with every out_clk toggle
//   busy         high while in RUN
//   done         one-cycle pulse on one-shot completion or executed stop
//
// All outputs are registered.

module tick_sched #(
    parameter int CNT_W        = 25,
    parameter int DEFAULT_HALF = 24999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             out_clk,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] half_act, half_nxt;
    logic             oneshot_act, oneshot_nxt;
    logic [CNT_W-1:0] shadow_half, shadow_half_nxt;
    logic             shadow_oneshot, shadow_oneshot_nxt;
    logic             pending, pending_nxt;
    logic             tog_cnt, tog_nxt;
    logic             out_nxt, tick_nxt, busy_nxt, done_nxt, ready_nxt;
    logic             accept;

    assign accept = cfg_valid && cfg_ready;

    // Next-state and next-output logic. Every register has a combinational
    // "next" value here; the flop process below only captures them.
    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        out_nxt            = out_clk;
        tick_nxt           = 1'b0;
        done_nxt           = 1'b0;
        half_nxt           = half_act;
        oneshot_nxt        = oneshot_act;
        shadow_half_nxt    = shadow_half;
        shadow_oneshot_nxt = shadow_oneshot;
        pending_nxt        = pending;
        tog_nxt            = tog_cnt;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                out_nxt     = 1'b0;
                tog_nxt     = 1'b0;
                pending_nxt = 1'b0;
                // Config loads directly, so a start in the same cycle
                // already runs with the new values.
                if (accept) begin
                    half_nxt    = cfg_half;
                    oneshot_nxt = cfg_oneshot;
                end
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (stop) begin
                    // Stop beats a terminal count on the same edge: no tick,
                    // and any shadowed config is thrown away.
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    out_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    pending_nxt = 1'b0;
                    tog_nxt     = 1'b0;
                end else begin
                    // cfg_ready is low while pending, so an accept here can
                    // never collide with the apply below.
                    if (accept) begin
                        shadow_half_nxt    = cfg_half;
                        shadow_oneshot_nxt = cfg_oneshot;
                        pending_nxt        = 1'b1;
                    end
                    if (cnt == half_act) begin
                        cnt_nxt  = '0;
                        out_nxt  = ~out_clk;
                        tick_nxt = 1'b1;
                        // New half-period only takes effect at a period
                        // boundary, so cnt can never overshoot it.
                        if (pending) begin
                            half_nxt    = shadow_half;
                            oneshot_nxt = shadow_oneshot;
                            pending_nxt = 1'b0;
                        end
                        // One-shot ends on the second toggle, which brings
                        // out_clk back to 0. The mode in force for this
                        // period decides, even if a new one is applied now.
                        if (oneshot_act && tog_cnt) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                            tog_nxt   = 1'b0;
                        end else begin
                            tog_nxt = ~tog_cnt;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt  = (state_nxt == RUN);
        ready_nxt = (state_nxt == IDLE) || !pending_nxt;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            out_clk        <= 1'b0;
            tick           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_ready      <= 1'b1;
            half_act       <= CNT_W'(DEFAULT_HALF);
            oneshot_act    <= 1'b0;
            shadow_half    <= '0;
            shadow_oneshot <= 1'b0;
            pending        <= 1'b0;
            tog_cnt        <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            out_clk        <= out_nxt;
            tick           <= tick_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            cfg_ready      <= ready_nxt;
            half_act       <= half_nxt;
            oneshot_act    <= oneshot_nxt;
            shadow_half    <= shadow_half_nxt;
            shadow_oneshot <= shadow_oneshot_nxt;
            pending        <= pending_nxt;
            tog_cnt        <= tog_nxt;
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched
// -------------
// Directed bench for tick_sched with a reduced parameter set
// (CNT_W = 8, DEFAULT_HALF = 4, so the reset period is 10 cycles).

module tb_tick_sched;

    localparam int CNT_W        = 8;
    localparam int DEFAULT_HALF = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic             out_clk;
    logic             tick;
    logic             busy;
    logic             done;

    int num_compared   = 0;
    int num_mismatched = 0;

    tick_sched #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_half    (cfg_half),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .out_clk     (out_clk),
        .tick        (tick),
        .busy        (busy),
        .done        (done)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Drive all inputs, then advance one clock edge and settle 1 ns past it.
    task automatic applyStimulus(input logic r, input logic v, input int half,
                                 input logic os, input logic st, input logic sp);
        rst         = r;
        cfg_valid   = v;
        cfg_half    = CNT_W'(half);
        cfg_oneshot = os;
        start       = st;
        stop        = sp;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input int got, input int exp);
        num_compared++;
        if (got != exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_half = '0;
        cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;

        // ---- Test 1: reset values, then half=3 continuous ----
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst out_clk", out_clk, 0);
        checkOutput("rst tick", tick, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst cfg_ready", cfg_ready, 1);

        applyStimulus(0, 1, 3, 0, 0, 0);
        checkOutput("t1 idle busy", busy, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t1 busy", busy, 1);
        checkOutput("t1 entry out_clk", out_clk, 0);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t1 tick c%0d", c), tick, (c % 4 == 0) ? 1 : 0);
            checkOutput($sformatf("t1 out_clk c%0d", c), out_clk, (c / 4) % 2);
        end
        checkOutput("t1 busy end", busy, 1);

        // ---- Test 2: reconfigure half=1 mid-period ----
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2 c13 tick", tick, 0);
        checkOutput("t2 c13 cfg_ready", cfg_ready, 1);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("t2 c14 cfg_ready", cfg_ready, 0);
        checkOutput("t2 c14 tick", tick, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2 c15 cfg_ready", cfg_ready, 0);
        checkOutput("t2 c15 tick", tick, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2 c16 tick", tick, 1);
        checkOutput("t2 c16 out_clk", out_clk, 0);
        checkOutput("t2 c16 cfg_ready", cfg_ready, 1);
        for (int c = 17; c <= 20; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t2 tick c%0d", c), tick, (c % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("t2 out_clk c%0d", c), out_clk, (c == 18 || c == 19) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t2 stop done", done, 1);
        checkOutput("t2 stop busy", busy, 0);
        checkOutput("t2 stop tick", tick, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2 done clear", done, 0);

        // ---- Test 3: one-shot half=2, config with start in the same cycle ----
        applyStimulus(0, 1, 2, 1, 1, 0);
        checkOutput("t3 busy", busy, 1);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t3 tick c%0d", c), tick, (c == 3 || c == 6) ? 1 : 0);
            checkOutput($sformatf("t3 done c%0d", c), done, (c == 6) ? 1 : 0);
            checkOutput($sformatf("t3 busy c%0d", c), busy, (c < 6) ? 1 : 0);
            checkOutput($sformatf("t3 out_clk c%0d", c), out_clk, (c >= 3 && c <= 5) ? 1 : 0);
        end

        // ---- Test 4: stop exactly at terminal count with out_clk high ----
        applyStimulus(0, 1, 2, 0, 1, 0);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkOutput("t4 pre out_clk", out_clk, 1);
        checkOutput("t4 pre tick", tick, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t4 stop tick", tick, 0);
        checkOutput("t4 stop out_clk", out_clk, 0);
        checkOutput("t4 stop done", done, 1);
        checkOutput("t4 stop busy", busy, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("t4 start+stop busy", busy, 0);
        checkOutput("t4 start+stop done", done, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4 still idle", busy, 0);

        // ---- Test 5: restart (counter cleared), pend config, then reset ----
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5 c2 tick", tick, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5 c3 tick", tick, 1);
        applyStimulus(0, 1, 7, 0, 0, 0);
        checkOutput("t5 pending cfg_ready", cfg_ready, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t5 rst out_clk", out_clk, 0);
        checkOutput("t5 rst tick", tick, 0);
        checkOutput("t5 rst busy", busy, 0);
        checkOutput("t5 rst done", done, 0);
        checkOutput("t5 rst cfg_ready", cfg_ready, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t5 tick c%0d", c), tick, (c % 5 == 0) ? 1 : 0);
            checkOutput($sformatf("t5 out_clk c%0d", c), out_clk, (c / 5) % 2);
        end

        // ---- Test 6: half=0, toggle every cycle ----
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t6 pre stop done", done, 1);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("t6 busy", busy, 1);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t6 tick c%0d", c), tick, 1);
            checkOutput($sformatf("t6 out_clk c%0d", c), out_clk, c % 2);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t6 stop done", done, 1);
        checkOutput("t6 stop out_clk", out_clk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
Run-time controller for the board's divided-clock time base. It owns a single prescale counter and produces a square `out_clk` plus a one-cycle `tick` enable. The half-period and run mode are configurable through a valid/ready port, and start/stop control sequences the counter. Downstream timing logic (display scan, game timers) uses it in place of a fixed-divide clock block.

Parameters:
- CNT_W, 25: counter and half-period width.
- DEFAULT_HALF, 24999: half-period loaded at reset. Toggle period is half+1 cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_half  in  CNT_W  requested half-period terminal count.
- cfg_oneshot  in  1  0 = continuous, 1 = one-shot.
- start  in  1  begin counting (level sampled each cycle).
- stop  in  1  abort counting.
- out_clk  out  1  divided square wave.
- tick  out  1  one-cycle pulse coincident with every out_clk toggle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a one-shot completes or a stop is executed.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, cnt 0, out_clk 0, tick 0, busy 0, done 0, cfg_ready 1, half_act DEFAULT_HALF, oneshot_act 0, pending 0, toggle count 0.
- All outputs are registered.
- States:
  - IDLE: cnt held at 0, out_clk 0.
  - RUN: counting.
- Counting in RUN:
  - Each cycle cnt += 1.
  - When cnt == half_act: cnt <= 0, out_clk inverts, tick = 1 on the same edge.
  - The first toggle is half_act+1 cycles after entering RUN.
  - half_act = 0 gives a toggle every cycle.
- IDLE → RUN:
  - Trigger: start=1 and stop=0. busy is 1 from the next cycle. cnt begins at 0.
  - start while in RUN is ignored.
- Configuration in IDLE:
  - cfg_ready = 1. An accepted request loads half_act/oneshot_act on that edge.
  - If start is asserted in the same cycle, the new values apply to that run.
- Configuration in RUN:
  - cfg_ready = 1 only while pending = 0.
  - An accepted request is stored in shadow registers and sets pending = 1, which drops cfg_ready.
  - At the next terminal count, half_act/oneshot_act load from shadow and pending clears. cfg_ready returns the following cycle.
  - The terminal compare on that edge uses the old half_act.
  - There is no mid-period change, so cnt never exceeds the new half.
- One-shot:
  - The toggle counter counts toggles in RUN.
  - After the second toggle (one full period, out_clk back at 0), state goes to IDLE and done pulses on that same edge.
  - busy is 0 from the next cycle.
- Stop:
  - stop=1 in RUN → next edge: IDLE, cnt 0, out_clk 0, done = 1, tick = 0, pending shadow discarded.
  - stop in IDLE has no effect and does not pulse done.
  - start and stop in the same cycle: stop wins.
- Simultaneous events:
  - A terminal count on the same edge as stop: stop wins, no tick.
  - A one-shot completion on the same edge as a pending apply: the shadow is applied, then IDLE.
- Reset mid-operation: every register returns to its reset value on the next edge regardless of state. Pending config is lost.
- Width: cnt and half are CNT_W unsigned. The counter never wraps past half_act.

Test Plan:
1. Reset, then cfg half=3, continuous, then start.
   - Required: tick at cycles 4, 8, 12… after RUN entry.
   - out_clk 0→1→0 with period 8; busy = 1.
2. Run with half=3; mid-period send cfg half=1.
   - Required: cfg_ready drops after acceptance.
   - The next toggle still comes 4 cycles after the previous one; later toggles come every 2 cycles.
   - cfg_ready returns 1 cycle after the apply.
3. One-shot with half=2.
   - Required: exactly 2 ticks, 3 cycles apart.
   - done pulse with the second tick; out_clk ends at 0; busy 0; no further ticks.
4. stop asserted when cnt = half with out_clk = 1.
   - Required: no tick; next cycle out_clk 0, cnt 0, done = 1, IDLE.
   - start and stop together in IDLE → stays IDLE, done = 0.
5. rst asserted in RUN with pending config.
   - Required: next cycle all outputs at reset values, half_act = DEFAULT_HALF, cfg_ready 1.
   - Reduced-parameter bench: a subsequent start gives period 2·(DEFAULT_HALF+1).
6. half=0 continuous.
   - Required: tick every cycle; out_clk toggles every cycle.
